// File: rtl/zoom_pkg.sv
// Shared constants and helpers for the zoom pipeline arithmetic blocks.
package zoom_pkg;

  localparam int MULT_LAT = 2;
  localparam int STAT_W   = 16;

  // Tag width needed to name one of n requesters; never narrower than 1 bit.
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_image_ip.sv
// Registered unsigned multiplier used by the zoom pipeline; one cycle from a/b to p.
module mult_image_ip #(
  parameter int WIDT_A = 9,
  parameter int WIDT_B = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDT_A-1:0]        a,
  input  logic [WIDT_B-1:0]        b,
  output logic [WIDT_A+WIDT_B-1:0] p
);

  logic [WIDT_A+WIDT_B-1:0] a_ext;
  logic [WIDT_A+WIDT_B-1:0] b_ext;

  assign a_ext = {{WIDT_B{1'b0}}, a};
  assign b_ext = {{WIDT_A{1'b0}}, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= a_ext * b_ext;
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin time-sharing of one registered multiplier among NUM_REQ requesters.
// Optional per-requester grant counters are built when MULT_SHARE_STATS_EN is defined.
module mult_share_arb
  import zoom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDT_A  = 9,
  parameter int WIDT_B  = 6
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*WIDT_A-1:0]   req_a,
  input  logic [NUM_REQ*WIDT_B-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
`ifdef MULT_SHARE_STATS_EN
  input  logic                        stat_clr,
  output logic [NUM_REQ*STAT_W-1:0]   stat_cnt,
`endif
  output logic [WIDT_A+WIDT_B-1:0]    rsp_p
);

  localparam int TAG_W = tag_width(NUM_REQ);

  logic [TAG_W-1:0]  ptr;
  logic [TAG_W-1:0]  cand;
  logic [TAG_W-1:0]  grant_idx;
  logic              grant_any;
  logic [WIDT_A-1:0] a_mux;
  logic [WIDT_B-1:0] b_mux;
  logic [WIDT_A-1:0] s1_a;
  logic [WIDT_B-1:0] s1_b;
  logic              s1_valid;
  logic              s2_valid;
  logic [TAG_W-1:0]  s1_tag;
  logic [TAG_W-1:0]  s2_tag;

  // Cyclic search for the first valid requester at or after ptr.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = TAG_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign a_mux = req_a[grant_idx*WIDT_A +: WIDT_A];
  assign b_mux = req_b[grant_idx*WIDT_B +: WIDT_B];

  // Operands load only on a handshake so rsp_p holds its last product when idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= grant_any;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (grant_any) begin
        s1_tag <= grant_idx;
        s1_a   <= a_mux;
        s1_b   <= b_mux;
        ptr    <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  mult_image_ip #(
    .WIDT_A (WIDT_A),
    .WIDT_B (WIDT_B)
  ) u_mult (
    .clk   (CLK),
    .rst_n (RST_N),
    .a     (s1_a),
    .b     (s1_b),
    .p     (rsp_p)
  );

  always_comb begin
    rsp_valid = '0;
    if (s2_valid) rsp_valid[s2_tag] = 1'b1;
  end

`ifdef MULT_SHARE_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_REQ];

  // Saturating grant counters; a clear on the same edge beats an increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr)
          cnt[i] <= '0;
        else if (grant_any && grant_idx == TAG_W'(i) && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_cnt[i*STAT_W +: STAT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: stimulus pushes expected products, a monitor checks them.
module tb_mult_share_arb;
  import zoom_pkg::*;

  localparam int N  = 4;
  localparam int WA = 9;
  localparam int WB = 6;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*WA-1:0]   req_a = '0;
  logic [N*WB-1:0]   req_b = '0;
  logic [N-1:0]      rsp_valid;
  logic [WA+WB-1:0]  rsp_p;
`ifdef MULT_SHARE_STATS_EN
  logic              stat_clr = 1'b0;
  logic [N*STAT_W-1:0] stat_cnt;
`endif

  typedef struct {
    int tag;
    int prod;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  mult_share_arb #(.NUM_REQ(N), .WIDT_A(WA), .WIDT_B(WB)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
`ifdef MULT_SHARE_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .rsp_p     (rsp_p)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*WA +: WA] = WA'(a);
    req_b[i*WB +: WB] = WB'(b);
  endtask

  // One cycle: drive the valid mask, check the grant, and record the product the grant will return.
  task automatic apply_stimulus(input logic [N-1:0] vld, input int exp_g, input int exp_p, input bit push);
    exp_t e;
    req_valid = vld;
    @(negedge CLK);
    check_output("req_ready", 64'(req_ready), (exp_g < 0) ? 64'd0 : (64'd1 << exp_g));
    if (push && exp_g >= 0) begin
      e.tag  = exp_g;
      e.prod = exp_p;
      e.due  = cyc + MULT_LAT;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation, on its due cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check_output("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_output("rsp_valid", 64'(rsp_valid), 64'd1 << e.tag);
          check_output("rsp_p", 64'(rsp_p), 64'(e.prod));
          check_output("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_output("missing_rsp", 64'(rsp_valid), 64'd1 << e.tag);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and combinational grant while in reset.
    RST_N = 1'b0;
    req_valid = 4'b0100;
    repeat (2) @(negedge CLK);
    check_output("reset_ready", 64'(req_ready), 64'b0100);
    check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("reset_rsp_p", 64'(rsp_p), 64'd0);
`ifdef MULT_SHARE_STATS_EN
    check_output("reset_stat_cnt", 64'(stat_cnt), 64'd0);
`endif
    req_valid = '0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Single request at the extreme operand values.
    set_ops(0, 511, 63);
    apply_stimulus(4'b0001, 0, 32193, 1'b1);
    repeat (3) apply_stimulus(4'b0000, -1, 0, 1'b0);

    for (int i = 0; i < N; i++) set_ops(i, i + 1, 2);

    // Pointer sits at 1: grant 2, then 3 ahead of 0, then 0.
    apply_stimulus(4'b0100, 2, 6, 1'b1);
    apply_stimulus(4'b1001, 3, 8, 1'b1);
    apply_stimulus(4'b0001, 0, 2, 1'b1);

    // Idle gap after a single grant to requester 1; pointer must still be 2.
    apply_stimulus(4'b0010, 1, 4, 1'b1);
    repeat (5) apply_stimulus(4'b0000, -1, 0, 1'b0);
    check_output("rsp_p_hold", 64'(rsp_p), 64'd4);
    apply_stimulus(4'b0101, 2, 6, 1'b1);
    apply_stimulus(4'b0001, 0, 2, 1'b1);
    repeat (3) apply_stimulus(4'b0000, -1, 0, 1'b0);

    // Reset between handshake and response: product is dropped, pointer returns to 0.
    apply_stimulus(4'b0100, 2, 6, 1'b0);
    RST_N = 1'b0;
    req_valid = '0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (3) apply_stimulus(4'b0000, -1, 0, 1'b0);

    // All requesters held valid: strict rotation from 0, one grant per cycle.
    apply_stimulus(4'b1111, 0, 2, 1'b1);
    apply_stimulus(4'b1111, 1, 4, 1'b1);
    apply_stimulus(4'b1111, 2, 6, 1'b1);
    apply_stimulus(4'b1111, 3, 8, 1'b1);
    apply_stimulus(4'b1111, 0, 2, 1'b1);
    apply_stimulus(4'b1111, 1, 4, 1'b1);
    repeat (4) apply_stimulus(4'b0000, -1, 0, 1'b0);

`ifdef MULT_SHARE_STATS_EN
    // Saturation of counter 1, then clear racing an increment on counter 0.
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int k = 0; k < 70000; k++) apply_stimulus(4'b0010, 1, 4, 1'b1);
    apply_stimulus(4'b0000, -1, 0, 1'b0);
    check_output("stat_cnt1_sat", 64'(stat_cnt[1*STAT_W +: STAT_W]), 64'hFFFF);
    check_output("stat_cnt0_zero", 64'(stat_cnt[0*STAT_W +: STAT_W]), 64'd0);
    check_output("stat_cnt2_zero", 64'(stat_cnt[2*STAT_W +: STAT_W]), 64'd0);
    check_output("stat_cnt3_zero", 64'(stat_cnt[3*STAT_W +: STAT_W]), 64'd0);
    stat_clr = 1'b1;
    apply_stimulus(4'b0001, 0, 2, 1'b1);
    stat_clr = 1'b0;
    check_output("stat_clr_wins", 64'(stat_cnt[0*STAT_W +: STAT_W]), 64'd0);
    check_output("stat_clr_cnt1", 64'(stat_cnt[1*STAT_W +: STAT_W]), 64'd0);
    apply_stimulus(4'b0001, 0, 2, 1'b1);
    check_output("stat_inc_after_clr", 64'(stat_cnt[0*STAT_W +: STAT_W]), 64'd1);
    repeat (3) apply_stimulus(4'b0000, -1, 0, 1'b0);
`endif

    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
